// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcodes, NOP word, fetch FSM encoding,
// IF/ID register layout and jump/branch target helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_JUMP   = 6'b000100;
  localparam logic [5:0] OP_BRANCH = 6'b001100;
  localparam logic [5:0] OP_ADDI   = 6'b001110;
  localparam logic [5:0] OP_LW     = 6'b100100;
  localparam logic [5:0] OP_SW     = 6'b100110;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // Jump keeps the 256 MB region of the delay slot address.
  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port: req/addr from fetch, valid/rdata back from memory.
// addr is held stable while req is high; valid may arrive after req drops.
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] rdata;

  modport master (output req, addr, input valid, rdata);
  modport slave  (input req, addr, output valid, rdata);
endinterface

// File: rtl/pc_next_calc.sv
// Redirect decision and target for the instruction held in IF/ID.
// Purely combinational; a stalled ID never redirects.
module pc_next_calc
  import mips_pkg::*;
(
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc_plus4,
  input  logic        jump,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic        id_valid,
  input  logic        stall,
  output logic        taken,
  output logic [31:0] target
);

  logic [5:0] unused_opcode;
  assign unused_opcode = id_instr[31:26];

  assign taken  = id_valid & ~stall & (jump | (branch & alu_zero));
  // jump wins over branch when control raises both
  assign target = jump ? jump_target(id_pc_plus4[31:28], id_instr[25:0])
                       : branch_target(id_pc_plus4, id_instr[15:0]);

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC, imem request FSM, one-word skid and IF/ID register. 1 instr/cycle
// with a 1-cycle memory; stall freezes IF/ID, a response caught under stall parks in skid.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jump,
  input  logic              branch,
  input  logic              alu_zero,
  if_stage_if.master        imem,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc_plus4,
  output logic              id_valid,
  output logic [31:0]       pc
);

  fetch_state_t state, state_nxt;
  ifid_t        ifid;
  logic [31:0]  skid;
  logic         taken;
  logic [31:0]  target;
  logic         rsp_fetch;
  logic         ifid_load;

  pc_next_calc u_pc_next_calc (
    .id_instr    (ifid.instr),
    .id_pc_plus4 (ifid.pc_plus4),
    .jump        (jump),
    .branch      (branch),
    .alu_zero    (alu_zero),
    .id_valid    (ifid.valid),
    .stall       (stall),
    .taken       (taken),
    .target      (target)
  );

  assign rsp_fetch = (state == ST_FETCH) && imem.valid;
  assign ifid_load = !stall && (rsp_fetch || (state == ST_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        // a redirect with the response still in flight must swallow it later
        if (taken)                    state_nxt = imem.valid ? ST_FETCH : ST_DROP;
        else if (imem.valid && stall) state_nxt = ST_HOLD;
      end
      ST_HOLD:  if (taken || !stall) state_nxt = ST_FETCH;
      ST_DROP:  if (imem.valid)      state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem.req  = (state == ST_FETCH);
    imem.addr = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pc <= RESET_PC;
    else if (taken)     pc <= target;
    else if (rsp_fetch) pc <= pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  skid <= NOP;
    else if (rsp_fetch && stall) skid <= imem.rdata;
  end

  // In HOLD the PC has already stepped past the parked word, so pc is its PC+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid <= '{instr: NOP, pc_plus4: 32'h0, valid: 1'b0};
    end else if (taken) begin
      ifid <= '{instr: NOP, pc_plus4: ifid.pc_plus4, valid: 1'b0};
    end else if (ifid_load) begin
      ifid <= (state == ST_HOLD) ? '{instr: skid, pc_plus4: pc, valid: 1'b1}
                                 : '{instr: imem.rdata, pc_plus4: pc + 32'd4, valid: 1'b1};
    end else if (!stall) begin
      ifid <= '{instr: NOP, pc_plus4: ifid.pc_plus4, valid: 1'b0};
    end
  end

  assign id_instr    = ifid.instr;
  assign id_pc_plus4 = ifid.pc_plus4;
  assign id_valid    = ifid.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural instruction memory of
// programmable latency and a minimal decoder driving jump/branch.
module tb_if_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic        branch;
  logic        alu_zero;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [31:0] pc;

  logic        jmp_en;
  logic        br_en;
  logic        inj_valid;
  int          lat;
  int          checks;
  int          failures;
  logic [31:0] mem [128];

  if_stage_if imem ();

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .jump        (jump),
    .branch      (branch),
    .alu_zero    (alu_zero),
    .imem        (imem),
    .id_instr    (id_instr),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign jump   = jmp_en & id_valid & (id_instr[31:26] == OP_JUMP);
  assign branch = br_en  & id_valid & (id_instr[31:26] == OP_BRANCH);

  // Memory: a request waits lat cycles; a held req after a response is the next request.
  logic        mdl_outst;
  int          mdl_cnt;
  logic [31:0] mdl_saddr;
  logic        mdl_valid;

  assign mdl_valid  = (imem.req || mdl_outst) && (mdl_cnt == 0);
  assign imem.valid = mdl_valid || inj_valid;
  assign imem.rdata = imem.req ? mem[imem.addr[8:2]] : mem[mdl_saddr[8:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_outst <= 1'b0;
      mdl_cnt   <= lat;
      mdl_saddr <= 32'h0;
    end else begin
      if (imem.req) mdl_saddr <= imem.addr;
      if (mdl_valid) begin
        mdl_outst <= 1'b0;
        mdl_cnt   <= imem.req ? lat - 1 : lat;
      end else if (imem.req || mdl_outst) begin
        mdl_outst <= 1'b1;
        if (mdl_cnt > 0) mdl_cnt <= mdl_cnt - 1;
      end else begin
        mdl_cnt <= lat;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic mem_init();
    for (int i = 0; i < 128; i++) mem[i] = 32'hE000_0000 | 32'(i * 4);
  endtask

  task automatic do_reset(input int l);
    lat       = l;
    stall     = 1'b0;
    jmp_en    = 1'b0;
    br_en     = 1'b0;
    alu_zero  = 1'b0;
    inj_valid = 1'b0;
    mem_init();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    lat = 1; stall = 0; jmp_en = 0; br_en = 0; alu_zero = 0; inj_valid = 0;
    mem_init();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem.req); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL reset_id_instr got=%h exp=%h", id_instr, 32'h0); end
    checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_id_pc_plus4 got=%h exp=%h", id_pc_plus4, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", imem.req); end
    @(negedge clk);
    checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
      failures++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h", imem.req, imem.addr, 32'h0);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    do_reset(1);
    repeat (3) @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      exp = 32'(4 * k);
      checks++; if (imem.addr !== exp || imem.req !== 1'b1) begin
        failures++; $display("FAIL seq_addr[%0d] got=%h exp=%h", k, imem.addr, exp);
      end
      checks++; if (id_pc_plus4 !== exp || id_valid !== 1'b1) begin
        failures++; $display("FAIL seq_ifid[%0d] got pc4=%h v=%b exp pc4=%h v=1", k, id_pc_plus4, id_valid, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    mem[1] = 32'h3A01_0005;
    repeat (3) @(negedge clk);
    checks++; if (imem.addr !== 32'h4 || imem.valid !== 1'b1) begin
      failures++; $display("FAIL stall_pre got addr=%h valid=%b exp addr=00000004 valid=1", imem.addr, imem.valid);
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL stall_hold_req[%0d] got=%b exp=0", k, imem.req); end
      checks++; if (id_instr !== 32'hE000_0000 || id_pc_plus4 !== 32'h4 || id_valid !== 1'b1) begin
        failures++; $display("FAIL stall_frozen[%0d] got %h/%h/%b exp e0000000/00000004/1", k, id_instr, id_pc_plus4, id_valid);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (id_instr !== 32'h3A01_0005 || id_pc_plus4 !== 32'h8 || id_valid !== 1'b1) begin
      failures++; $display("FAIL stall_release got %h/%h/%b exp 3a010005/00000008/1", id_instr, id_pc_plus4, id_valid);
    end
    checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h8) begin
      failures++; $display("FAIL stall_resume got req=%b addr=%h exp req=1 addr=00000008", imem.req, imem.addr);
    end
    repeat (2) @(negedge clk);
    checks++; if (id_instr !== 32'hE000_0008 || id_pc_plus4 !== 32'hC || id_valid !== 1'b1) begin
      failures++; $display("FAIL stall_next got %h/%h/%b exp e0000008/0000000c/1", id_instr, id_pc_plus4, id_valid);
    end
  endtask

  task automatic test_jump();
    do_reset(1);
    mem[3] = 32'h1000_0040;
    jmp_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id_valid && id_pc_plus4 == 32'h10) break;
    end
    checks++; if (id_pc_plus4 !== 32'h10 || id_instr !== 32'h1000_0040) begin
      failures++; $display("FAIL jump_pre got pc4=%h instr=%h exp 00000010/10000040", id_pc_plus4, id_instr);
    end
    @(negedge clk);
    checks++; if (imem.addr !== 32'h100 || imem.req !== 1'b1) begin
      failures++; $display("FAIL jump_target got addr=%h req=%b exp 00000100/1", imem.addr, imem.req);
    end
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP_WORD) begin
      failures++; $display("FAIL jump_flush got v=%b instr=%h exp 0/%h", id_valid, id_instr, NOP_WORD);
    end
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h104 || id_instr !== 32'hE000_0100) begin
      failures++; $display("FAIL jump_land got %h/%h/%b exp e0000100/00000104/1", id_instr, id_pc_plus4, id_valid);
    end
  endtask

  task automatic test_branch();
    do_reset(1);
    mem[7] = 32'h3000_FFFE;
    br_en = 1'b1;
    alu_zero = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (id_valid && id_pc_plus4 == 32'h20) break;
    end
    checks++; if (id_pc_plus4 !== 32'h20 || id_instr !== 32'h3000_FFFE) begin
      failures++; $display("FAIL br_pre got pc4=%h instr=%h exp 00000020/3000fffe", id_pc_plus4, id_instr);
    end
    @(negedge clk);
    checks++; if (pc !== 32'h18 || imem.addr !== 32'h18 || id_valid !== 1'b0) begin
      failures++; $display("FAIL br_taken got pc=%h addr=%h v=%b exp 00000018/00000018/0", pc, imem.addr, id_valid);
    end
    alu_zero = 1'b0;
    @(negedge clk);
    checks++; if (id_pc_plus4 !== 32'h1C || id_valid !== 1'b1) begin
      failures++; $display("FAIL br_land got pc4=%h v=%b exp 0000001c/1", id_pc_plus4, id_valid);
    end
    @(negedge clk);
    checks++; if (id_pc_plus4 !== 32'h20 || id_instr !== 32'h3000_FFFE) begin
      failures++; $display("FAIL br_again got pc4=%h instr=%h exp 00000020/3000fffe", id_pc_plus4, id_instr);
    end
    @(negedge clk);
    checks++; if (pc !== 32'h24 || id_valid !== 1'b1 || id_pc_plus4 !== 32'h24) begin
      failures++; $display("FAIL br_not_taken got pc=%h v=%b pc4=%h exp 00000024/1/00000024", pc, id_valid, id_pc_plus4);
    end
  endtask

  task automatic test_drop();
    logic        stale_seen;
    logic        drop_rsp_seen;
    logic        got_target;
    logic        have_first;
    logic [31:0] first_addr;
    do_reset(3);
    mem[3] = 32'h1000_0040;
    jmp_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (id_valid && id_pc_plus4 == 32'h10) break;
    end
    checks++; if (id_pc_plus4 !== 32'h10 || imem.valid !== 1'b0 || imem.addr !== 32'h10) begin
      failures++; $display("FAIL drop_pre got pc4=%h valid=%b addr=%h exp 00000010/0/00000010", id_pc_plus4, imem.valid, imem.addr);
    end
    @(negedge clk);
    checks++; if (imem.req !== 1'b0 || pc !== 32'h100 || id_valid !== 1'b0) begin
      failures++; $display("FAIL drop_enter got req=%b pc=%h v=%b exp 0/00000100/0", imem.req, pc, id_valid);
    end
    stale_seen = 0; drop_rsp_seen = 0; got_target = 0; have_first = 0; first_addr = '0;
    for (int i = 0; i < 15; i++) begin
      if (!imem.req && imem.valid) drop_rsp_seen = 1;
      if (imem.req && !have_first) begin have_first = 1; first_addr = imem.addr; end
      if (id_valid && id_pc_plus4 == 32'h14) stale_seen = 1;
      if (id_valid && id_pc_plus4 == 32'h104 && id_instr == 32'hE000_0100) got_target = 1;
      @(negedge clk);
    end
    checks++; if (drop_rsp_seen !== 1'b1) begin failures++; $display("FAIL drop_rsp got=%b exp=1", drop_rsp_seen); end
    checks++; if (stale_seen !== 1'b0) begin failures++; $display("FAIL drop_stale got=%b exp=0", stale_seen); end
    checks++; if (have_first !== 1'b1 || first_addr !== 32'h100) begin
      failures++; $display("FAIL drop_first_req got=%h exp=00000100", first_addr);
    end
    checks++; if (got_target !== 1'b1) begin failures++; $display("FAIL drop_land got=%b exp=1", got_target); end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem.req !== 1'b0 || pc !== 32'h0) begin
      failures++; $display("FAIL mid_rst_pc got req=%b pc=%h exp 0/00000000", imem.req, pc);
    end
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc_plus4 !== 32'h0) begin
      failures++; $display("FAIL mid_rst_ifid got %h/%h/%b exp 00000000/00000000/0", id_instr, id_pc_plus4, id_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0 || id_valid !== 1'b0) begin
      failures++; $display("FAIL mid_rst_first got req=%b addr=%h v=%b exp 1/00000000/0", imem.req, imem.addr, id_valid);
    end
    repeat (2) @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h4 || id_instr !== 32'hE000_0000) begin
      failures++; $display("FAIL mid_rst_fetch got %h/%h/%b exp e0000000/00000004/1", id_instr, id_pc_plus4, id_valid);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    stall     = 1'b0;
    jmp_en    = 1'b0;
    br_en     = 1'b0;
    alu_zero  = 1'b0;
    inj_valid = 1'b0;
    lat       = 1;
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_branch();
    test_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
